// File: rtl/blksync_pkg.sv
// Shared types and line-level constants for the block-synchronous frame receiver.
// BLKSYNC_PARITY_EN adds the PARITY state to the state encoding.
package blksync_pkg;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

`ifdef BLKSYNC_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2, PARITY = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2} state_e;
`endif

endpackage

// File: rtl/blksync_shift.sv
// LSB-first payload shift register: bits enter at the MSB and move toward bit 0,
// so after WIDTH loads the first received bit sits at index 0.
module blksync_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             din,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (clear) begin
      data <= '0;
    end else if (load) begin
      data <= {din, data[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/blksync_frame_rx.sv
// Serial frame receiver: start(1), WIDTH payload bits LSB first, optional even parity, stop(0).
// Define BLKSYNC_PARITY_EN to enable the parity bit and its check.
module blksync_frame_rx
  import blksync_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic             rx_bit,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               shift_clear, shift_load;
  logic [WIDTH-1:0]   shift_data;
  logic               frame_good, frame_bad;
  logic               parity_bad;

`ifdef BLKSYNC_PARITY_EN
  logic parity_bad_nxt;
`else
  assign parity_bad = 1'b0;
`endif

  blksync_shift #(.WIDTH(WIDTH)) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (shift_clear),
    .load  (shift_load),
    .din   (rx_bit),
    .data  (shift_data)
  );

  // The counter holds at LAST_IDX on the final payload bit, so it never wraps.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shift_clear = 1'b0;
    shift_load  = 1'b0;
    frame_good  = 1'b0;
    frame_bad   = 1'b0;
`ifdef BLKSYNC_PARITY_EN
    parity_bad_nxt = parity_bad;
`endif
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_bit == START_BIT) begin
            state_nxt   = DATA;
            cnt_nxt     = '0;
            shift_clear = 1'b1;
          end
        end
        DATA: begin
          shift_load = 1'b1;
          if (cnt == LAST_IDX) begin
`ifdef BLKSYNC_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
`ifdef BLKSYNC_PARITY_EN
        PARITY: begin
          parity_bad_nxt = (rx_bit != (^shift_data));
          state_nxt      = STOP;
        end
`endif
        STOP: begin
          state_nxt = IDLE;
          if ((rx_bit == STOP_BIT) && !parity_bad) begin
            frame_good = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef BLKSYNC_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_bad <= 1'b0;
    end else begin
      parity_bad <= parity_bad_nxt;
    end
  end
`endif

  // A good frame may replace a word that is being accepted in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      if (frame_good) begin
        if (!out_valid || out_ready) begin
          out_data  <= shift_data;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_blksync_frame_rx.sv
// Self-checking bench for blksync_frame_rx (WIDTH=8): scoreboard of expected words
// popped on each out_valid&&out_ready handshake, plus frame_err pulse counting.
module tb_blksync_frame_rx;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             rx_valid;
  logic             rx_bit;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             frame_err;
  logic             overrun;

  int total_checks = 0;
  int bad_checks   = 0;
  int err_seen     = 0;
  int err_expected = 0;
  logic [WIDTH-1:0] exp_q[$];

  blksync_frame_rx #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_bit    (rx_bit),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Outputs are read 1ns after the falling edge; out_ready read here is what the next rising edge sees.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (frame_err) err_seen++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          checkOutput("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge after the bit was sampled.
  task automatic send_bit(input logic b);
    rx_valid = 1'b1;
    rx_bit   = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_bit   = 1'b0;
  endtask

  task automatic send_bit_gapped(input logic b, input bit gapped);
    if (gapped) begin
      rx_valid = 1'b0;
      rx_bit   = ~b;
      @(negedge clk);
    end
    send_bit(b);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic stop_bit, input bit gapped);
    send_bit_gapped(1'b1, gapped);
    for (int i = 0; i < WIDTH; i++) send_bit_gapped(data[i], gapped);
`ifdef BLKSYNC_PARITY_EN
    send_bit_gapped(^data, gapped);
`endif
    send_bit_gapped(stop_bit, gapped);
  endtask

  initial begin
    logic [WIDTH-1:0] rnd;
    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_bit    = 1'b0;
    out_ready = 1'b1;
    idle(3);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data",  32'(out_data),  32'd0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
    checkOutput("reset_overrun",   32'(overrun),   32'd0);
    rst_n = 1'b1;
    idle(2);

    // Basic frame, out_valid one cycle after the stop bit.
    exp_q.push_back(8'h5A);
    applyStimulus(8'h5A, 1'b0, 1'b0);
    #1;
    checkOutput("latency_out_valid", 32'(out_valid), 32'd1);
    checkOutput("latency_out_data",  32'(out_data),  32'h5A);
    @(negedge clk);
    idle(2);
    checkOutput("basic_no_err", 32'(err_seen), 32'(err_expected));

    // Bad stop bit: one frame_err pulse, no word, then a clean frame.
    applyStimulus(8'h99, 1'b1, 1'b0);
    err_expected++;
    idle(3);
    checkOutput("stop_err_pulses", 32'(err_seen), 32'(err_expected));
    checkOutput("stop_err_no_word", 32'(out_valid), 32'd0);
    exp_q.push_back(8'h3C);
    applyStimulus(8'h3C, 1'b0, 1'b0);
    idle(3);

    // Overrun: second frame dropped while first is unaccepted.
    out_ready = 1'b0;
    exp_q.push_back(8'h11);
    applyStimulus(8'h11, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b0);
    idle(1);
    checkOutput("ovr_hold_valid", 32'(out_valid), 32'd1);
    checkOutput("ovr_hold_data",  32'(out_data),  32'h11);
    checkOutput("ovr_flag",       32'(overrun),   32'd1);
    out_ready = 1'b1;
    idle(2);
    checkOutput("ovr_drain_valid", 32'(out_valid), 32'd0);
    checkOutput("ovr_sticky",      32'(overrun),   32'd1);

    // rx_valid toggling every cycle gives the same result.
    exp_q.push_back(8'hA5);
    applyStimulus(8'hA5, 1'b0, 1'b1);
    idle(3);

    // Reset mid-frame abandons it and clears sticky overrun.
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_overrun",   32'(overrun),   32'd0);
    checkOutput("midrst_out_data",  32'(out_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'h0F);
    applyStimulus(8'h0F, 1'b0, 1'b0);
    idle(3);
    checkOutput("midrst_no_err", 32'(err_seen), 32'(err_expected));

    // Back-to-back frames with no dead cycle.
    for (int k = 0; k < 4; k++) begin
      rnd = WIDTH'($urandom_range(0, 255));
      exp_q.push_back(rnd);
      applyStimulus(rnd, 1'b0, 1'b0);
    end
    idle(3);
    checkOutput("b2b_overrun", 32'(overrun), 32'd0);

`ifdef BLKSYNC_PARITY_EN
    // Wrong parity for 0x07 (correct even parity is 1).
    send_bit(1'b1);
    for (int i = 0; i < WIDTH; i++) send_bit(i < 3);
    send_bit(1'b0);
    send_bit(1'b0);
    err_expected++;
    idle(3);
    checkOutput("parity_err_pulses", 32'(err_seen), 32'(err_expected));
    checkOutput("parity_err_no_word", 32'(out_valid), 32'd0);
    exp_q.push_back(8'h07);
    applyStimulus(8'h07, 1'b0, 1'b0);
    idle(3);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("total_err_pulses",   32'(err_seen),     32'(err_expected));

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
